// File: rtl/pgm_sched.sv
// -----------------------------------------------------------------------------
// pgm_sched -- packet-generator launch scheduler
//
// Sequences the generator read engine: issues one launch request at a time,
// marks every (PROBE_INT+1)-th launch as a latency probe, inserts a
// programmable idle gap after each packet, and stops after PKT_TOTAL packets
// or on a software stop. A small register file gives configuration and
// counter readback.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_wr/cfg_rd     single-cycle register write / read strobes
//   cfg_addr/wdata    register address and write data
//   cfg_rdata/rvalid  read data and its valid pulse, one cycle after cfg_rd
//   pkt_req           launch request to the read engine (registered)
//   pkt_probe         current launch is a probe (stable while requesting)
//   pkt_ack           read engine accepted the launch
//   pkt_done          read engine issued the last beat of the packet
//   out_alf           downstream almost-full, suppresses pkt_req
//   busy              scheduler is in REQ, XMIT or GAP
//   finish_flag       generation finished (level, FIN state)
// -----------------------------------------------------------------------------
module pgm_sched #(
   parameter int GAP_W = 32,
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_wr,
   input  logic        cfg_rd,
   input  logic [3:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   output logic        cfg_rvalid,
   output logic        pkt_req,
   output logic        pkt_probe,
   input  logic        pkt_ack,
   input  logic        pkt_done,
   input  logic        out_alf,
   output logic        busy,
   output logic        finish_flag
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_XMIT = 3'd2,
      S_GAP  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [GAP_W-1:0]   r_gap;
   logic [CNT_W-1:0]   r_pint;
   logic [CNT_W-1:0]   r_total;
   logic [CNT_W-1:0]   r_sent;
   logic [CNT_W-1:0]   r_pcnt;
   logic [CNT_W-1:0]   r_since;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_stop_pend;
   logic               r_is_probe;
   logic               r_pkt_req;
   logic               r_busy;
   logic               r_fin;
   logic [31:0]        r_rdata;
   logic               r_rvalid;

   logic               w_ctrl_wr;
   logic               w_start;
   logic               w_stop;
   logic               w_soft;
   logic               w_ack_take;
   logic               w_done_take;
   logic               w_clear;
   logic               w_stop_pend;
   logic               w_probe_nxt;
   logic               w_req_entry;
   logic [CNT_W-1:0]   w_sent_inc;
   logic [CNT_W-1:0]   w_since_nxt;
   logic [31:0]        w_rdata;

   // Stop dominates start when both bits arrive in the same CTRL write.
   assign w_ctrl_wr   = cfg_wr && (cfg_addr == 4'd0);
   assign w_start     = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
   assign w_stop      = w_ctrl_wr && cfg_wdata[1];
   assign w_soft      = w_ctrl_wr && cfg_wdata[2];

   // A stop seen while a launch is pending or in flight is remembered so the
   // packet in flight always completes before FIN.
   assign w_stop_pend = r_stop_pend || (w_stop && (r_state == S_REQ || r_state == S_XMIT));
   assign w_sent_inc  = r_sent + CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_ack_take  = 1'b0;
      w_done_take = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_REQ;
               w_clear     = 1'b1;
            end
         end
         S_REQ: begin
            // Only an ack against a visible request counts.
            if (pkt_ack && r_pkt_req) begin
               w_ack_take  = 1'b1;
               w_state_nxt = S_XMIT;
            end else if (r_stop_pend || w_stop) begin
               w_state_nxt = S_FIN;
            end
         end
         S_XMIT: begin
            if (pkt_done) begin
               w_done_take = 1'b1;
               if (w_stop_pend || (r_total != '0 && w_sent_inc == r_total))
                  w_state_nxt = S_FIN;
               else if (r_gap == '0)
                  w_state_nxt = S_REQ;
               else
                  w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (w_stop)
               w_state_nxt = S_FIN;
            else if (r_gap_cnt <= GAP_W'(1))
               w_state_nxt = S_REQ;
         end
         S_FIN: begin
            if (w_start) begin
               w_state_nxt = S_REQ;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_soft) begin
         w_state_nxt = S_IDLE;
         w_ack_take  = 1'b0;
         w_done_take = 1'b0;
         w_clear     = 1'b0;
      end
   end

   always_comb begin
      w_since_nxt = r_since;
      if (w_clear)
         w_since_nxt = '0;
      else if (w_done_take)
         w_since_nxt = r_is_probe ? '0 : r_since + CNT_W'(1);
   end

   // Probe decision is frozen on REQ entry so pkt_probe stays stable in REQ
   // and still identifies the packet while it is in XMIT.
   assign w_probe_nxt = (r_pint != '0) && (w_since_nxt == r_pint);
   assign w_req_entry = (w_state_nxt == S_REQ) && (r_state != S_REQ);

   always_comb begin
      case (cfg_addr)
         4'd0:    w_rdata = 32'(r_state);
         4'd1:    w_rdata = 32'(r_gap);
         4'd2:    w_rdata = 32'(r_pint);
         4'd3:    w_rdata = 32'(r_total);
         4'd4:    w_rdata = 32'(r_sent);
         4'd5:    w_rdata = 32'(r_pcnt);
         default: w_rdata = 32'hFFFF_FFFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gap       <= '0;
         r_pint      <= '0;
         r_total     <= '0;
         r_sent      <= '0;
         r_pcnt      <= '0;
         r_since     <= '0;
         r_gap_cnt   <= '0;
         r_stop_pend <= 1'b0;
         r_is_probe  <= 1'b0;
         r_pkt_req   <= 1'b0;
         r_busy      <= 1'b0;
         r_fin       <= 1'b0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         // Registered from next state so the request appears in the first REQ
         // cycle; out_alf acts with one cycle of latency.
         r_pkt_req <= (w_state_nxt == S_REQ) && !out_alf;
         r_busy    <= (w_state_nxt == S_REQ) || (w_state_nxt == S_XMIT) ||
                      (w_state_nxt == S_GAP);
         r_fin     <= (w_state_nxt == S_FIN);
         r_rvalid  <= cfg_rd && !w_soft;
         r_rdata   <= (cfg_rd && !w_soft) ? w_rdata : '0;

         if (cfg_wr) begin
            case (cfg_addr)
               4'd1:    r_gap   <= GAP_W'(cfg_wdata);
               4'd2:    r_pint  <= CNT_W'(cfg_wdata);
               4'd3:    r_total <= CNT_W'(cfg_wdata);
               default: ;
            endcase
         end

         if (w_soft) begin
            r_sent      <= '0;
            r_pcnt      <= '0;
            r_since     <= '0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
            r_is_probe  <= 1'b0;
         end else begin
            if (w_clear) begin
               r_sent <= '0;
               r_pcnt <= '0;
            end else if (w_done_take) begin
               r_sent <= w_sent_inc;
               if (r_is_probe)
                  r_pcnt <= r_pcnt + CNT_W'(1);
            end
            r_since     <= w_since_nxt;
            r_stop_pend <= w_clear ? 1'b0 : w_stop_pend;
            if (w_done_take)
               r_gap_cnt <= r_gap;
            else if (r_state == S_GAP)
               r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            if (w_req_entry)
               r_is_probe <= w_probe_nxt;
         end
      end
   end

   assign pkt_req     = r_pkt_req;
   assign pkt_probe   = r_is_probe && (r_state == S_REQ);
   assign busy        = r_busy;
   assign finish_flag = r_fin;
   assign cfg_rdata   = r_rdata;
   assign cfg_rvalid  = r_rvalid;

endmodule

// File: tb/tb_pgm_sched.sv
// -----------------------------------------------------------------------------
// tb_pgm_sched -- self-checking bench for pgm_sched
//
// Directed scenarios drive the register interface and play the read engine.
// Expected read data and expected probe bits are queued when stimulus is
// issued; a monitor pops them whenever the DUT returns read data or a launch
// is accepted.
// -----------------------------------------------------------------------------
module tb_pgm_sched;

   localparam logic [3:0] A_CTRL  = 4'd0;
   localparam logic [3:0] A_GAP   = 4'd1;
   localparam logic [3:0] A_PINT  = 4'd2;
   localparam logic [3:0] A_TOTAL = 4'd3;
   localparam logic [3:0] A_SENT  = 4'd4;
   localparam logic [3:0] A_PCNT  = 4'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_wr;
   logic        cfg_rd;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        cfg_rvalid;
   logic        pkt_req;
   logic        pkt_probe;
   logic        pkt_ack;
   logic        pkt_done;
   logic        out_alf;
   logic        busy;
   logic        finish_flag;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] rd_q[$];
   logic        launch_q[$];

   pgm_sched #(.GAP_W(32), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_wr     (cfg_wr),
      .cfg_rd     (cfg_rd),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .cfg_rvalid (cfg_rvalid),
      .pkt_req    (pkt_req),
      .pkt_probe  (pkt_probe),
      .pkt_ack    (pkt_ack),
      .pkt_done   (pkt_done),
      .out_alf    (out_alf),
      .busy       (busy),
      .finish_flag(finish_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Monitor: sampled 1 time unit after the falling edge, after stimulus.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && pkt_req && pkt_ack) begin
         if (launch_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL launch_unexpected: accepted launch with probe=%b, none expected", pkt_probe);
         end else begin
            chkb("launch_probe", pkt_probe, launch_q.pop_front());
         end
      end
      if (rst_n && cfg_rvalid) begin
         if (rd_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL read_unexpected: rdata=0x%0h, no read outstanding", cfg_rdata);
         end else begin
            chk("read_data", cfg_rdata, rd_q.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic cfg_read(input logic [3:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      cfg_rd = 1'b1; cfg_addr = a;
      @(negedge clk);
      cfg_rd = 1'b0;
      chkb("rvalid_latency", cfg_rvalid, 1'b1);
   endtask

   task automatic wait_req(input string tag, output bit ok);
      int t = 0;
      while (pkt_req !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = (pkt_req === 1'b1);
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL %s_req_timeout: pkt_req low for %0d cycles, expected high", tag, t);
      end
   endtask

   // Plays one packet: ack 1 cycle after req, done dd cycles after ack.
   task automatic serve_one(input int dd, input bit stop_mid, input string tag);
      bit ok;
      wait_req(tag, ok);
      if (ok) begin
         @(negedge clk); pkt_ack = 1'b1;
         @(negedge clk); pkt_ack = 1'b0;
         if (stop_mid) begin
            cfg_wr = 1'b1; cfg_addr = A_CTRL; cfg_wdata = 32'h2;
         end
         repeat (dd - 1) begin
            @(negedge clk);
            cfg_wr = 1'b0;
         end
         pkt_done = 1'b1;
         @(negedge clk);
         pkt_done = 1'b0;
      end
   endtask

   task automatic count_req(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pkt_req) hi++;
      end
   endtask

   initial begin
      int  gap_seen;
      int  hi;
      bit  ok;
      rst_n = 1'b0; cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      pkt_ack = 1'b0; pkt_done = 1'b0; out_alf = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chkb("rst_pkt_req", pkt_req, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_finish", finish_flag, 1'b0);
      chkb("rst_rvalid", cfg_rvalid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_read(A_CTRL, 32'd0);
      cfg_read(A_GAP, 32'd0);
      cfg_read(A_TOTAL, 32'd0);
      cfg_read(A_SENT, 32'd0);

      // Two packets, GAP=3
      cfg_write(A_GAP, 32'd3);
      cfg_write(A_PINT, 32'd0);
      cfg_write(A_TOTAL, 32'd2);
      launch_q.push_back(1'b0); launch_q.push_back(1'b0);
      cfg_write(A_CTRL, 32'h1);
      chkb("t1_busy_run", busy, 1'b1);
      serve_one(4, 1'b0, "t1_p1");
      gap_seen = 0;
      while (!pkt_req && gap_seen < 100) begin
         gap_seen++;
         @(negedge clk);
      end
      chk("t1_gap_cycles", 32'(gap_seen), 32'd3);
      serve_one(4, 1'b0, "t1_p2");
      chkb("t1_finish", finish_flag, 1'b1);
      chkb("t1_busy_idle", busy, 1'b0);
      cfg_read(A_SENT, 32'd2);
      cfg_read(A_CTRL, 32'd4);

      // Probe pattern, PROBE_INT=2, six packets back to back
      cfg_write(A_PINT, 32'd2);
      cfg_write(A_TOTAL, 32'd6);
      cfg_write(A_GAP, 32'd0);
      launch_q.push_back(1'b0); launch_q.push_back(1'b0); launch_q.push_back(1'b1);
      launch_q.push_back(1'b0); launch_q.push_back(1'b0); launch_q.push_back(1'b1);
      cfg_write(A_CTRL, 32'h1);
      for (int i = 0; i < 6; i++) serve_one(2, 1'b0, "t2");
      chkb("t2_finish", finish_flag, 1'b1);
      cfg_read(A_PCNT, 32'd2);
      cfg_read(A_SENT, 32'd6);

      // Unlimited run, stop during XMIT of packet 5
      cfg_write(A_PINT, 32'd0);
      cfg_write(A_TOTAL, 32'd0);
      for (int i = 0; i < 5; i++) launch_q.push_back(1'b0);
      cfg_write(A_CTRL, 32'h1);
      for (int i = 0; i < 4; i++) serve_one(4, 1'b0, "t3");
      serve_one(4, 1'b1, "t3_stop");
      chkb("t3_finish", finish_flag, 1'b1);
      cfg_read(A_SENT, 32'd5);
      cfg_read(A_CTRL, 32'd4);
      count_req(20, hi);
      chk("t3_no_req_after_fin", 32'(hi), 32'd0);

      // out_alf backpressure in REQ; ack while req low is ignored
      cfg_write(A_TOTAL, 32'd1);
      cfg_write(A_CTRL, 32'h1);
      chkb("t4_req_up", pkt_req, 1'b1);
      out_alf = 1'b1;
      hi = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (pkt_req) hi++;
         if (i == 3) pkt_ack = 1'b1;
         if (i == 4) pkt_ack = 1'b0;
      end
      chk("t4_req_low_alf", 32'(hi), 32'd0);
      out_alf = 1'b0;
      @(negedge clk);
      chkb("t4_req_rise", pkt_req, 1'b1);
      cfg_read(A_SENT, 32'd0);
      launch_q.push_back(1'b0);
      serve_one(2, 1'b0, "t4");
      cfg_read(A_SENT, 32'd1);

      // start|stop together in IDLE, then soft reset during GAP
      cfg_write(A_CTRL, 32'h4);
      cfg_read(A_CTRL, 32'd0);
      cfg_write(A_CTRL, 32'h3);
      cfg_read(A_CTRL, 32'd0);
      chkb("t5_busy_startstop", busy, 1'b0);
      cfg_write(A_GAP, 32'd20);
      cfg_write(A_PINT, 32'd5);
      cfg_write(A_TOTAL, 32'd9);
      launch_q.push_back(1'b0);
      cfg_write(A_CTRL, 32'h1);
      serve_one(2, 1'b0, "t5");
      cfg_read(A_CTRL, 32'd3);
      cfg_write(A_CTRL, 32'h4);
      chkb("t5_busy_soft", busy, 1'b0);
      cfg_read(A_CTRL, 32'd0);
      cfg_read(A_SENT, 32'd0);
      cfg_read(A_PCNT, 32'd0);
      cfg_read(A_GAP, 32'd20);
      cfg_read(A_PINT, 32'd5);
      cfg_read(A_TOTAL, 32'd9);
      count_req(30, hi);
      chk("t5_no_req_after_soft", 32'(hi), 32'd0);

      // Short run, readback, RO write ignored, unmapped address
      cfg_write(A_TOTAL, 32'd3);
      cfg_write(A_GAP, 32'd1);
      for (int i = 0; i < 3; i++) launch_q.push_back(1'b0);
      cfg_write(A_CTRL, 32'h1);
      for (int i = 0; i < 3; i++) serve_one(3, 1'b0, "t6");
      cfg_read(A_SENT, 32'd3);
      cfg_write(A_SENT, 32'd77);
      cfg_read(A_SENT, 32'd3);
      cfg_read(4'd9, 32'hFFFF_FFFF);
      cfg_read(A_PCNT, 32'd0);

      // Asynchronous reset in XMIT
      cfg_write(A_TOTAL, 32'd0);
      launch_q.push_back(1'b0);
      cfg_write(A_CTRL, 32'h1);
      wait_req("t7", ok);
      @(negedge clk); pkt_ack = 1'b1;
      @(negedge clk); pkt_ack = 1'b0;
      cfg_read(A_CTRL, 32'd2);
      chkb("t7_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chkb("t7_rst_busy", busy, 1'b0);
      chkb("t7_rst_req", pkt_req, 1'b0);
      chkb("t7_rst_probe", pkt_probe, 1'b0);
      chkb("t7_rst_finish", finish_flag, 1'b0);
      chkb("t7_rst_rvalid", cfg_rvalid, 1'b0);
      chk("t7_rst_rdata", cfg_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_read(A_CTRL, 32'd0);
      cfg_read(A_PINT, 32'd0);

      repeat (2) @(negedge clk);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
      chk("launch_q_drained", 32'(launch_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pgm_sched.md
Name: pgm_sched

Overview:
Scheduler that sequences the packet-generator read engine.
- Decides when the next stored packet is launched, with a programmable inter-packet gap.
- Decides which launches are latency probes.
- Stops after a programmed packet count or on a software stop.
- Sits between the configuration path and the generator read engine; drives its start/probe/finish controls and exposes counters for readback.

Parameters:
GAP_W, 32, width of inter-packet gap register and counter
CNT_W, 32, width of packet total, probe interval and status counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_wr  in  1  register write strobe, single cycle
cfg_rd  in  1  register read strobe, single cycle
cfg_addr  in  4  register address
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, valid the cycle after cfg_rd
cfg_rvalid  out  1  read data valid pulse
pkt_req  out  1  request to read engine to launch one stored packet
pkt_probe  out  1  qualifies pkt_req: this launch is a probe
pkt_ack  in  1  read engine accepted the request (first beat issued)
pkt_done  in  1  read engine issued the last beat of the launched packet
out_alf  in  1  downstream almost-full
busy  out  1  scheduler not in IDLE or FIN
finish_flag  out  1  generation finished (level)

Behaviour:
Register map (32-bit; CNT_W/GAP_W zero-extended on read):
- 0 CTRL (W): bit0 start, bit1 stop, bit2 soft_rst. Self-clearing strobes; read returns {29'b0, state[2:0]}.
- 1 GAP: idle cycles between pkt_done and the next pkt_req.
- 2 PROBE_INT: N regular packets, then 1 probe; 0 = never probe.
- 3 PKT_TOTAL: packets to send; 0 = unlimited.
- 4 SENT_CNT (RO), 5 PROBE_CNT (RO).
- Any other address reads 32'hFFFFFFFF; writes to it and to RO addresses are ignored.

Reset (rst_n low):
- All outputs 0; state IDLE.
- GAP, PROBE_INT, PKT_TOTAL, counters, since_probe, stop_pend all 0.

Soft reset (CTRL bit2, takes effect next cycle, from any state):
- Same as rst_n except GAP, PROBE_INT and PKT_TOTAL are kept.

FSM states IDLE=0, REQ=1, XMIT=2, GAP=3, FIN=4:
- IDLE: on start, clear SENT_CNT, PROBE_CNT, since_probe and stop_pend -> REQ.
- REQ:
  - pkt_req = !out_alf.
  - pkt_probe = (PROBE_INT!=0 && since_probe==PROBE_INT), held stable while in REQ.
  - pkt_ack while pkt_req=1 -> XMIT.
  - stop_pend, or stop this cycle, with no ack -> FIN.
- XMIT:
  - pkt_req=0; wait for pkt_done.
  - On pkt_done: SENT_CNT+1. If probe: PROBE_CNT+1 and since_probe=0; else since_probe+1.
  - Then go to FIN if stop_pend, or if PKT_TOTAL!=0 and SENT_CNT+1==PKT_TOTAL.
  - Otherwise go to REQ if GAP==0, else to GAP with gap_cnt=GAP.
- GAP:
  - gap_cnt decrements each cycle; at gap_cnt==1 -> REQ.
  - Exactly GAP idle cycles lie between the pkt_done cycle and the first cycle of pkt_req.
  - Stop -> FIN next cycle.
- FIN: finish_flag=1; start -> REQ with counters cleared as in IDLE.

Control and timing rules:
- Stop in XMIT sets stop_pend; the packet in flight always completes. Stop in IDLE is ignored.
- Start and stop in the same write: stop wins, start ignored.
- Start while busy is ignored.
- pkt_ack outside REQ and pkt_done outside XMIT are ignored.
- Ack and done in the same cycle in REQ: only the ack is taken.
- GAP, PROBE_INT and PKT_TOTAL writes while busy are sampled at the next XMIT exit or REQ entry.
- PKT_TOTAL written lower than SENT_CNT while running: run continues until the 32-bit wrap equality or a stop.
- SENT_CNT and PROBE_CNT wrap modulo 2^CNT_W.
- out_alf drops pkt_req combinationally-registered: pkt_req is a registered output equal to (state==REQ && !out_alf) from the previous cycle's inputs. One cycle of latency from out_alf to pkt_req.
- busy = state in {REQ, XMIT, GAP}, registered.

Test Plan:
- GAP=3, PROBE_INT=0, PKT_TOTAL=2, start; ack 1 cycle after req, done 4 cycles after ack -> two req/ack/done sequences; exactly 3 idle cycles between first done and second req; SENT_CNT=2; finish_flag=1 the cycle after second done; busy=0.
- PROBE_INT=2, PKT_TOTAL=6, GAP=0 -> pkt_probe pattern 0,0,1,0,0,1; PROBE_CNT=2; SENT_CNT=6.
- PKT_TOTAL=0, GAP=0; issue stop mid-XMIT of packet 5 -> done still accepted, SENT_CNT=5, FIN, no further pkt_req.
- Hold out_alf=1 for 10 cycles during REQ -> pkt_req stays low; it rises the cycle after out_alf falls; no ack is counted while it is low.
- Write start|stop together in IDLE -> stays IDLE; then soft_rst during GAP -> state IDLE, counters 0, GAP/PROBE_INT/PKT_TOTAL read back unchanged.
- Read addr 4 after a run -> cfg_rvalid and cfg_rdata=SENT_CNT one cycle after cfg_rd; read addr 9 -> 32'hFFFFFFFF; assert rst_n low mid-XMIT -> all outputs 0 immediately.
